// File: rtl/tree_io_pkg.sv
// ----------------------------------------------------------------------------
// tree_io_pkg
// Shared definitions for the serial feature-frame loader:
//   - default feature width and feature count
//   - assembler FSM state encoding
//   - helper for sizing counters
// ----------------------------------------------------------------------------
package tree_io_pkg;

  localparam int FEAT_W_DEF = 8;
  localparam int N_FEAT_DEF = 16;

  // IDLE waits for a strobed sframe; SHIFT assembles a frame.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } fsm_state_t;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feat_shift_reg.sv
// ----------------------------------------------------------------------------
// feat_shift_reg
// Serial-in shift register for one feature word, MSB first, with bit counter.
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   i_shift     : accept i_bit this cycle
//   i_start     : this bit is bit 1 of a new word (counter restarts)
//   i_bit       : serial data bit
//   o_word      : word formed by the stored bits plus the current i_bit;
//                 meaningful in the cycle o_word_done is high
//   o_word_done : i_bit is the last bit of a word
// FEAT_W must be at least 2.
// ----------------------------------------------------------------------------
module feat_shift_reg
  import tree_io_pkg::*;
#(
  parameter int FEAT_W = FEAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_shift,
  input  logic              i_start,
  input  logic              i_bit,
  output logic [FEAT_W-1:0] o_word,
  output logic              o_word_done
);

  localparam int BC_W = cnt_width(FEAT_W);

  // Only FEAT_W-1 earlier bits need storage: the final bit arrives on
  // i_bit in the cycle the word completes, so the word is available
  // combinationally without an extra cycle of latency.
  logic [FEAT_W-2:0] r_sr;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [BC_W-1:0]   w_bit_idx;

  // A start bit always counts as bit position 0, whatever was pending.
  assign w_bit_idx   = i_start ? '0 : r_bit_cnt;
  assign o_word      = {r_sr, i_bit};
  assign o_word_done = i_shift && (w_bit_idx == BC_W'(FEAT_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else if (i_shift) begin
      r_sr      <= o_word[FEAT_W-2:0];
      r_bit_cnt <= o_word_done ? '0 : w_bit_idx + 1'b1;
    end
  end

endmodule

// File: rtl/feature_frame_loader.sv
// ----------------------------------------------------------------------------
// feature_frame_loader
// Assembles a serial bit stream into a frame of N_FEAT features of FEAT_W
// bits and presents it as a held, parallel frame with valid/ready handoff.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, overrides every input
//   sframe     : frame sync, qualified by sstrobe; marks bit 1 of a frame
//   sdata      : serial data, MSB first, feature 1 first
//   sstrobe    : sdata/sframe qualifier
//   feat_bus   : held frame, feature k (1-based) at [k*FEAT_W-1:(k-1)*FEAT_W]
//   X16        : copy of the last feature of the held frame
//   feat_valid : held frame is valid (the HOLD flag)
//   feat_ready : consumer accepts the held frame
//   overrun    : one-cycle pulse, a completed frame was dropped
//   sync_err   : one-cycle pulse, a partial frame was aborted by sframe
// ----------------------------------------------------------------------------
module feature_frame_loader
  import tree_io_pkg::*;
#(
  parameter int FEAT_W = FEAT_W_DEF,
  parameter int N_FEAT = N_FEAT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sframe,
  input  logic                     sdata,
  input  logic                     sstrobe,
  output logic [N_FEAT*FEAT_W-1:0] feat_bus,
  output logic [FEAT_W-1:0]        X16,
  output logic                     feat_valid,
  input  logic                     feat_ready,
  output logic                     overrun,
  output logic                     sync_err
);

  localparam int FC_W = cnt_width(N_FEAT);

  fsm_state_t      r_state;
  fsm_state_t      w_state_next;

  logic [FC_W-1:0] r_feat_cnt;
  logic [FC_W-1:0] w_feat_idx;
  logic [FC_W-1:0] w_feat_cnt_next;

  logic            w_shift;
  logic            w_start;
  logic            w_sync_abort;
  logic            w_word_done;
  logic            w_frame_done;
  logic            w_load;
  logic            w_drop;
  logic [FEAT_W-1:0] w_word;

  logic            r_hold;
  logic            r_overrun;
  logic            r_sync_err;

  // --------------------------------------------------------------------------
  // Input decode. A strobed sframe always starts a frame; in SHIFT it also
  // aborts the partial one. Plain strobed bits only count while in SHIFT.
  // --------------------------------------------------------------------------
  assign w_start      = sstrobe && sframe;
  assign w_shift      = sstrobe && (sframe || (r_state == ST_SHIFT));
  assign w_sync_abort = w_start && (r_state == ST_SHIFT);

  feat_shift_reg #(
    .FEAT_W (FEAT_W)
  ) u_shift (
    .clk         (clk),
    .rst         (rst),
    .i_shift     (w_shift),
    .i_start     (w_start),
    .i_bit       (sdata),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  // Slot being filled this cycle; a start bit always targets feature 1.
  assign w_feat_idx   = w_start ? '0 : r_feat_cnt;
  assign w_frame_done = w_word_done && (w_feat_idx == FC_W'(N_FEAT - 1));

  always_comb begin
    w_feat_cnt_next = r_feat_cnt;
    if (w_shift) begin
      if (w_word_done) begin
        w_feat_cnt_next = w_frame_done ? '0 : w_feat_idx + 1'b1;
      end else begin
        w_feat_cnt_next = w_feat_idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register plus next-state / handoff decode.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_next = ST_SHIFT;
      ST_SHIFT: w_state_next = ST_SHIFT;
      default:  w_state_next = ST_IDLE;
    endcase
    if (w_frame_done) begin
      w_state_next = ST_IDLE;
      // A held frame is only replaced if the consumer takes it this cycle.
      if (!r_hold || feat_ready) begin
        w_load = 1'b1;
      end else begin
        w_drop = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Counters, HOLD flag and event pulses.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_feat_cnt <= '0;
      r_hold     <= 1'b0;
      r_overrun  <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_feat_cnt <= w_feat_cnt_next;
      r_overrun  <= w_drop;
      r_sync_err <= w_sync_abort;
      // A load in the same cycle as an accept keeps the flag set.
      if (w_load) begin
        r_hold <= 1'b1;
      end else if (r_hold && feat_ready) begin
        r_hold <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Assembly and output banks, one slot per feature. The last slot's word is
  // bypassed straight into the output bank because it completes in the same
  // cycle the frame is handed over.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N_FEAT; gi++) begin : g_slot
      logic [FEAT_W-1:0] r_asm_slot;
      logic [FEAT_W-1:0] r_out_slot;
      logic              w_wr_here;

      assign w_wr_here = w_word_done && (w_feat_idx == FC_W'(gi));

      always_ff @(posedge clk) begin
        if (w_wr_here) begin
          r_asm_slot <= w_word;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_out_slot <= '0;
        end else if (w_load) begin
          r_out_slot <= w_wr_here ? w_word : r_asm_slot;
        end
      end

      assign feat_bus[gi*FEAT_W +: FEAT_W] = r_out_slot;
    end
  endgenerate

  assign X16        = feat_bus[N_FEAT*FEAT_W-1 -: FEAT_W];
  assign feat_valid = r_hold;
  assign overrun    = r_overrun;
  assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_feature_frame_loader.sv
// ----------------------------------------------------------------------------
// tb_feature_frame_loader
// Randomized bench for feature_frame_loader. A frame-level reference model
// (queue of received bits, converted to features arithmetically) predicts
// feat_valid, feat_bus, X16, overrun and sync_err after every clock edge.
// ----------------------------------------------------------------------------
module tb_feature_frame_loader;

  localparam int W  = 8;
  localparam int N  = 16;
  localparam int NB = N * W;
  localparam int BW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          sframe;
  logic          sdata;
  logic          sstrobe;
  logic          feat_ready;
  logic [BW-1:0] feat_bus;
  logic [W-1:0]  X16;
  logic          feat_valid;
  logic          overrun;
  logic          sync_err;

  feature_frame_loader #(
    .FEAT_W (W),
    .N_FEAT (N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sframe     (sframe),
    .sdata      (sdata),
    .sstrobe    (sstrobe),
    .feat_bus   (feat_bus),
    .X16        (X16),
    .feat_valid (feat_valid),
    .feat_ready (feat_ready),
    .overrun    (overrun),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit            m_bits[$];
  bit            m_in_frame;
  bit            m_valid;
  logic [BW-1:0] m_bank;
  bit            m_ovr;
  bit            m_sync;

  int n_cmp;
  int n_bad;
  int n_ovr_seen;
  int n_sync_seen;
  int rdy_mode;   // 0: ready low, 1: ready high, 2: random per cycle

  task automatic check_val(input string tag, input logic [BW-1:0] got,
                           input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] bits_to_frame();
    logic [BW-1:0] f;
    f = '0;
    for (int k = 0; k < N; k++) begin
      int v;
      v = 0;
      for (int b = 0; b < W; b++) v = v * 2 + int'(m_bits[k*W + b]);
      f[k*W +: W] = W'(v);
    end
    return f;
  endfunction

  function automatic logic [BW-1:0] rand_frame();
    logic [BW-1:0] f;
    for (int k = 0; k < N; k++) f[k*W +: W] = W'($urandom);
    return f;
  endfunction

  function automatic bit cur_rdy();
    case (rdy_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return 1'($urandom % 2);
    endcase
  endfunction

  // One clock: drive inputs, advance the model, check outputs on negedge.
  task automatic step(input bit r, input bit sf, input bit sd, input bit st,
                      input bit rdy);
    bit load;
    rst = r; sframe = sf; sdata = sd; sstrobe = st; feat_ready = rdy;
    if (r) begin
      m_bits.delete();
      m_in_frame = 0; m_valid = 0; m_bank = '0; m_ovr = 0; m_sync = 0;
    end else begin
      load = 0; m_ovr = 0; m_sync = 0;
      if (st) begin
        if (sf) begin
          if (m_in_frame) m_sync = 1;
          m_bits.delete();
          m_bits.push_back(sd);
          m_in_frame = 1;
        end else if (m_in_frame) begin
          m_bits.push_back(sd);
        end
      end
      if (m_in_frame && m_bits.size() == NB) begin
        if (!m_valid || rdy) begin
          load = 1;
          m_bank = bits_to_frame();
        end else begin
          m_ovr = 1;
        end
        m_bits.delete();
        m_in_frame = 0;
      end
      if (load) m_valid = 1;
      else if (m_valid && rdy) m_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check_val("feat_valid", BW'(feat_valid), BW'(m_valid));
    check_val("feat_bus", feat_bus, m_bank);
    check_val("X16", BW'(X16), BW'(m_bank[BW-1 -: W]));
    check_val("overrun", BW'(overrun), BW'(m_ovr));
    check_val("sync_err", BW'(sync_err), BW'(m_sync));
    if (overrun) n_ovr_seen++;
    if (sync_err) n_sync_seen++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, cur_rdy());
  endtask

  // Random-length gap of unstrobed junk, then one strobed bit.
  task automatic send_bit(input bit sf, input bit b, input int gapmax,
                          input bit force_rdy);
    int g;
    g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    repeat (g) step(1'b0, 1'($urandom % 2), 1'($urandom % 2), 1'b0, cur_rdy());
    step(1'b0, sf, b, 1'b1, force_rdy ? 1'b1 : cur_rdy());
  endtask

  // Sends the first n_bits bits of frame f, sframe on the first bit.
  task automatic send_frame(input logic [BW-1:0] f, input int n_bits,
                            input int gapmax, input bit rdy_last);
    for (int i = 0; i < n_bits; i++) begin
      send_bit(i == 0, f[(i / W) * W + (W - 1 - (i % W))], gapmax,
               rdy_last && (i == NB - 1));
    end
  endtask

  initial begin
    logic [BW-1:0] fa, fb, fc, fe, ff, fi;
    int ovr0, sync0;

    n_cmp = 0; n_bad = 0; n_ovr_seen = 0; n_sync_seen = 0;
    rdy_mode = 0;
    m_in_frame = 0; m_valid = 0; m_bank = '0; m_ovr = 0; m_sync = 0;
    rst = 1'b1; sframe = 1'b0; sdata = 1'b0; sstrobe = 1'b0; feat_ready = 1'b0;

    // Reset, with junk on the inputs to show rst wins.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("rst_bus", feat_bus, '0);
    idle(3);

    // Frame 0x01..0x10, no gaps, consumer not ready.
    for (int k = 0; k < N; k++) fa[k*W +: W] = W'(k + 1);
    send_frame(fa, NB, 0, 1'b0);
    $display("frame A sent: valid=%0b X16=%h", feat_valid, X16);
    check_val("s1_valid", BW'(feat_valid), BW'(1));
    check_val("s1_x16", BW'(X16), BW'(8'h10));
    check_val("s1_f1", BW'(feat_bus[7:0]), BW'(8'h01));
    idle(2);

    // Second frame completes while held and not accepted: dropped.
    ovr0 = n_ovr_seen;
    fb = rand_frame();
    send_frame(fb, NB, 1, 1'b0);
    idle(2);
    $display("frame B sent: overrun pulses=%0d", n_ovr_seen - ovr0);
    check_val("s2_ovr_cnt", BW'(n_ovr_seen - ovr0), BW'(1));
    check_val("s2_bus_kept", feat_bus, fa);

    // Accept in the very cycle a new frame completes: seamless reload.
    ovr0 = n_ovr_seen;
    fc = rand_frame();
    send_frame(fc, NB, 0, 1'b1);
    $display("frame C sent: valid=%0b", feat_valid);
    check_val("s3_valid", BW'(feat_valid), BW'(1));
    check_val("s3_bus", feat_bus, fc);
    check_val("s3_no_ovr", BW'(n_ovr_seen - ovr0), BW'(0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("s3_drain", BW'(feat_valid), BW'(0));

    // sframe reasserted at bit 40 of a frame.
    rdy_mode = 1;
    sync0 = n_sync_seen;
    send_frame(rand_frame(), 40, 0, 1'b0);
    fe = rand_frame();
    send_frame(fe, NB, 0, 1'b0);
    idle(2);
    $display("frame E sent after abort: sync_err pulses=%0d", n_sync_seen - sync0);
    check_val("s4_sync_cnt", BW'(n_sync_seen - sync0), BW'(1));
    check_val("s4_bus", feat_bus, fe);

    // Strobe gaps of 0..5 cycles: same content as gap-free.
    ff = rand_frame();
    send_frame(ff, NB, 5, 1'b0);
    idle(2);
    $display("frame F sent with gaps");
    check_val("s5_bus", feat_bus, ff);

    // Reset at bit 70, then unsynced strobed bits.
    rdy_mode = 0;
    send_frame(rand_frame(), 70, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (50) step(1'b0, 1'b0, 1'($urandom % 2), 1'b1, 1'b0);
    $display("reset mid-frame: valid=%0b", feat_valid);
    check_val("s6_valid", BW'(feat_valid), BW'(0));
    check_val("s6_bus", feat_bus, '0);
    check_val("s6_x16", BW'(X16), BW'(0));
    fi = rand_frame();
    send_frame(fi, NB, 2, 1'b0);
    check_val("s6_bus_new", feat_bus, fi);
    check_val("s6_valid_new", BW'(feat_valid), BW'(1));

    // Random traffic: ready patterns, gaps and aborted partial frames.
    for (int it = 0; it < 40; it++) begin
      rdy_mode = int'($urandom_range(2, 0));
      if ($urandom_range(4, 0) == 0)
        send_frame(rand_frame(), int'($urandom_range(NB - 1, 1)), 2, 1'b0);
      send_frame(rand_frame(), NB, int'($urandom_range(3, 0)), 1'($urandom % 2));
      idle(int'($urandom_range(3, 0)));
      $display("random frame %0d: valid=%0b ovr_total=%0d sync_total=%0d",
               it, feat_valid, n_ovr_seen, n_sync_seen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
